// File: rtl/div_pkg.sv
// Shared types and constants for the divider job sequencer.
// Width defaults and the FSM state encoding live here.
package div_pkg;

   localparam int AW          = 10;
   localparam int DW          = 5;
   localparam int RW          = 6;
   localparam int DIV_LAT_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      FIN,
      OUT
   } state_e;

endpackage

// File: rtl/div_lat_timer.sv
// Loadable 8-bit down-counter timing the divider latency.
// Holds at zero; load has priority over enable.
module div_lat_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // next count: load, else decrement while enabled and nonzero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/div_job_sequencer.sv
// Front-end for the restoring divider: accepts a job, starts the
// divider, waits its fixed latency, captures and presents the result.
module div_job_sequencer #(
   parameter int AW      = div_pkg::AW,
   parameter int DW      = div_pkg::DW,
   parameter int RW      = div_pkg::RW,
   parameter int DIV_LAT = div_pkg::DIV_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_a,
   input  logic [DW-1:0] in_d,
   output logic [AW-1:0] div_ain,
   output logic [DW-1:0] div_din,
   output logic          div_start,
   output logic          div_finish,
   input  logic [RW-1:0] div_quo,
   input  logic [RW-1:0] div_rem,
   input  logic          div_divby0,
   input  logic          div_overflow,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_quo,
   output logic [RW-1:0] out_rem,
   output logic          out_divby0,
   output logic          out_overflow,
   output logic          busy
);

   import div_pkg::*;

   localparam logic [7:0] LAT_LOAD = 8'(DIV_LAT - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] ain_q, ain_d;
   logic [DW-1:0] din_q, din_d;
   logic [RW-1:0] quo_q, quo_d;
   logic [RW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;
   logic          ov_q, ov_d;
   logic          t_load;
   logic          t_en;
   logic          t_zero;

   div_lat_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .en       (t_en),
      .load_val (LAT_LOAD),
      .zero     (t_zero)
   );

   // next-state, operand/result capture and handshake outputs
   always_comb begin
      state_d    = state_q;
      ain_d      = ain_q;
      din_d      = din_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dz_d       = dz_q;
      ov_d       = ov_q;
      in_ready   = 1'b0;
      div_start  = 1'b0;
      div_finish = 1'b0;
      out_valid  = 1'b0;
      t_load     = 1'b0;
      t_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ain_d = in_a;
               din_d = in_d;
               if (in_d != '0) begin
                  state_d = ISSUE;
               end else begin
                  // zero divisor bypasses the divider entirely
                  quo_d   = '0;
                  rem_d   = '0;
                  dz_d    = 1'b1;
                  ov_d    = 1'b0;
                  state_d = OUT;
               end
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            t_load    = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (t_zero) begin
               state_d = FIN;
            end else begin
               t_en = 1'b1;
            end
         end
         FIN: begin
            div_finish = 1'b1;
            quo_d      = div_quo;
            rem_d      = div_rem;
            dz_d       = div_divby0;
            ov_d       = div_overflow;
            state_d    = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ain_q   <= '0;
         din_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ain_q   <= ain_d;
         din_q   <= din_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   assign div_ain      = ain_q;
   assign div_din      = din_q;
   assign out_quo      = quo_q;
   assign out_rem      = rem_q;
   assign out_divby0   = dz_q;
   assign out_overflow = ov_q;
   assign busy         = (state_q != IDLE);

endmodule
